mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/project_types.sv | 27 ++
 rtl/bus_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_types.sv
// rtl/project_types.sv - shared project types: address/data aliases, arbiter state, port command
package project_types;

   typedef logic [31:0] inst_addr_t;
   typedef logic [31:0] inst_data_t;
   typedef logic [31:0] ram_addr_t;
   typedef logic [31:0] ram_data_t;
   typedef logic        chip_en_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2
   } arb_state_t;

   // Command presented on the shared memory port.
   typedef struct packed {
      chip_en_t   en;
      logic       we;
      logic [3:0] sel;
      ram_addr_t  addr;
      ram_data_t  wdata;
   } bus_cmd_t;

   localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - per-transaction cycle counter that flags an unanswered bus command
module bus_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   input  logic done,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   // An ack in the last allowed cycle wins over expiry.
   assign expired = run && !done && (count == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && !done && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (fetch/data) arbiter for one shared memory port with starvation guard and timeout
module mem_arbiter
   import project_types::*;
#(
   parameter int TIMEOUT    = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  inst_addr_t  if_addr,
   output inst_data_t  if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_sel,
   input  ram_addr_t   d_addr,
   input  ram_data_t   d_wdata,
   output ram_data_t   d_rdata,
   output logic        d_ack,
   output chip_en_t    bus_ce,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output ram_addr_t   bus_addr,
   output ram_data_t   bus_wdata,
   input  ram_data_t   bus_rdata,
   input  logic        bus_ack,
   output logic        err
);

   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   arb_state_t  state, state_next;
   bus_cmd_t    cmd, cmd_next;
   logic [SW-1:0] starve, starve_next;
   inst_data_t  if_rdata_next;
   ram_data_t   d_rdata_next;
   logic        if_ack_next, d_ack_next, err_next;
   logic        wd_clear, wd_run, wd_expired;
   logic        starve_room;
   logic        finish;
   ram_data_t   resp;

   assign starve_room = (starve < SW'(STARVE_MAX));
   assign wd_run      = (state != ST_IDLE);
   assign finish      = bus_ack || wd_expired;
   // An aborted transaction returns zero data.
   assign resp        = bus_ack ? bus_rdata : '0;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .run     (wd_run),
      .done    (bus_ack),
      .expired (wd_expired)
   );

   always_comb begin
      state_next    = state;
      cmd_next      = cmd;
      starve_next   = starve;
      if_rdata_next = if_rdata;
      d_rdata_next  = d_rdata;
      if_ack_next   = 1'b0;
      d_ack_next    = 1'b0;
      err_next      = 1'b0;
      wd_clear      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (d_req && (!if_req || starve_room)) begin
               state_next = ST_DATA;
               cmd_next   = '{en: 1'b1, we: d_we, sel: d_sel, addr: d_addr, wdata: d_wdata};
               wd_clear   = 1'b1;
               if (if_req) begin
                  starve_next = starve + 1'b1;
               end
            end else if (if_req) begin
               state_next  = ST_FETCH;
               cmd_next    = '{en: 1'b1, we: 1'b0, sel: SEL_WORD, addr: if_addr, wdata: '0};
               wd_clear    = 1'b1;
               starve_next = '0;
            end
         end
         ST_FETCH, ST_DATA: begin
            if (finish) begin
               state_next  = ST_IDLE;
               cmd_next.en = 1'b0;
               err_next    = !bus_ack;
               if (state == ST_FETCH) begin
                  if_rdata_next = resp;
                  if_ack_next   = 1'b1;
               end else begin
                  d_rdata_next = resp;
                  d_ack_next   = 1'b1;
               end
            end
         end
         default: begin
            state_next  = ST_IDLE;
            cmd_next.en = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cmd      <= '0;
         starve   <= '0;
         if_rdata <= '0;
         d_rdata  <= '0;
         if_ack   <= 1'b0;
         d_ack    <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_next;
         cmd      <= cmd_next;
         starve   <= starve_next;
         if_rdata <= if_rdata_next;
         d_rdata  <= d_rdata_next;
         if_ack   <= if_ack_next;
         d_ack    <= d_ack_next;
         err      <= err_next;
      end
   end

   assign bus_ce    = cmd.en;
   assign bus_we    = cmd.we;
   assign bus_sel   = cmd.sel;
   assign bus_addr  = cmd.addr;
   assign bus_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a memory responder and arbitration model
module tb_mem_arbiter;
   import project_types::*;

   localparam int TIMEOUT    = 16;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_sel;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        bus_ce;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        err;

   always #5 clk = ~clk;

   mem_arbiter #(
      .TIMEOUT    (TIMEOUT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_sel     (d_sel),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .bus_ce    (bus_ce),
      .bus_we    (bus_we),
      .bus_sel   (bus_sel),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .err       (err)
   );

   typedef struct {
      bit          fetch;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   typedef struct {
      bit          fetch;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
   } cmd_t;

   exp_t exp_q[$];
   cmd_t cmd_q[$];
   int   checks = 0;
   int   errors = 0;
   int   starve_m = 0;
   bit   late_ack = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h2402_0001;
      return {a[15:0], 16'h0} ^ 32'h1357_9BDF ^ a;
   endfunction

   function automatic exp_t make_exp(input bit f, input logic [31:0] a, input int w);
      exp_t e;
      e.fetch = f;
      e.err   = (w >= TIMEOUT);
      e.rdata = e.err ? 32'h0 : mem_val(a);
      return e;
   endfunction

   function automatic cmd_t make_cmd(input bit f, input logic we, input logic [3:0] sel,
                                     input logic [31:0] a, input logic [31:0] wd, input int w);
      cmd_t c;
      c.fetch = f;
      c.we    = we;
      c.sel   = sel;
      c.addr  = a;
      c.wdata = wd;
      c.waits = w;
      return c;
   endfunction

   // memory responder: acks after the queued number of wait cycles
   initial begin : slave
      cmd_t c;
      bit   active;
      int   k;
      bus_ack   = 1'b0;
      bus_rdata = 32'hDEAD_BEEF;
      active    = 1'b0;
      k         = 0;
      c         = make_cmd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0);
      forever begin
         @(posedge clk);
         #1;
         bus_ack   = 1'b0;
         bus_rdata = 32'hDEAD_BEEF;
         if (bus_ce !== 1'b1) begin
            active = 1'b0;
         end else begin
            if (!active) begin
               active = 1'b1;
               k      = 0;
               check("grant_expected", 64'(cmd_q.size() > 0), 64'd1);
               if (cmd_q.size() > 0) begin
                  c = cmd_q.pop_front();
                  if (c.fetch)
                     check("fetch_cmd", {bus_we, bus_sel, bus_addr}, {1'b0, 4'hF, c.addr});
                  else
                     check("data_cmd", {bus_we, bus_sel, bus_addr}, {c.we, c.sel, c.addr});
                  if (!c.fetch && c.we)
                     check("data_wdata", bus_wdata, c.wdata);
               end else begin
                  c = make_cmd(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0);
               end
            end
            if (k == c.waits) begin
               bus_ack   = 1'b1;
               bus_rdata = mem_val(bus_addr);
            end
            k++;
         end
         if (late_ack) bus_ack = 1'b1;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (if_ack === 1'b1 || d_ack === 1'b1) begin
            check("ack_exclusive", 64'(if_ack & d_ack), 64'd0);
            check("ack_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("ack_port", 64'(if_ack), 64'(e.fetch));
               check("ack_rdata", e.fetch ? if_rdata : d_rdata, e.rdata);
               check("ack_err", 64'(err), 64'(e.err));
            end
         end else if (err === 1'b1) begin
            check("err_without_ack", 64'(err), 64'd0);
         end
      end
   end

   initial begin : global_limit
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   // Model: data wins unless fetch is waiting and the data streak reached STARVE_MAX.
   task automatic run_episode(input bit do_f, input bit do_d, input logic [31:0] fa,
                              input bit dwe, input logic [3:0] dsel, input logic [31:0] da,
                              input logic [31:0] dwd, input int fw, input int dw,
                              output int lat, output int ce_cycles);
      bit data_first;
      int n;
      data_first = do_d && (!do_f || starve_m < STARVE_MAX);
      if (data_first) begin
         exp_q.push_back(make_exp(1'b0, da, dw));
         cmd_q.push_back(make_cmd(1'b0, dwe, dsel, da, dwd, dw));
         if (do_f && starve_m < STARVE_MAX) starve_m++;
      end
      if (do_f) begin
         exp_q.push_back(make_exp(1'b1, fa, fw));
         cmd_q.push_back(make_cmd(1'b1, 1'b0, 4'hF, fa, 32'h0, fw));
         starve_m = 0;
      end
      if (do_d && !data_first) begin
         exp_q.push_back(make_exp(1'b0, da, dw));
         cmd_q.push_back(make_cmd(1'b0, dwe, dsel, da, dwd, dw));
      end
      if_addr   = fa;
      d_we      = dwe;
      d_sel     = dsel;
      d_addr    = da;
      d_wdata   = dwd;
      if_req    = do_f;
      d_req     = do_d;
      lat       = -1;
      ce_cycles = 0;
      n         = 0;
      while ((if_req || d_req) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (bus_ce === 1'b1) ce_cycles++;
         if ((if_ack === 1'b1 || d_ack === 1'b1) && lat < 0) lat = n;
         if (if_ack === 1'b1) if_req = 1'b0;
         if (d_ack === 1'b1) d_req = 1'b0;
      end
      check("episode_complete", 64'({if_req, d_req}), 64'd0);
      if (if_req || d_req) begin
         if_req = 1'b0;
         d_req  = 1'b0;
         exp_q.delete();
         cmd_q.delete();
      end
   endtask

   task automatic run_starvation();
      int nd;
      int dc;
      int n;
      nd = 0;
      while (starve_m < STARVE_MAX) begin
         exp_q.push_back(make_exp(1'b0, 32'h1000 + 32'(nd * 4), 0));
         cmd_q.push_back(make_cmd(1'b0, 1'b0, 4'hF, 32'h1000 + 32'(nd * 4), 32'h0, 0));
         starve_m++;
         nd++;
      end
      exp_q.push_back(make_exp(1'b1, 32'h300, 1));
      cmd_q.push_back(make_cmd(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1));
      starve_m = 0;
      if_addr = 32'h300;
      d_we    = 1'b0;
      d_sel   = 4'hF;
      d_addr  = 32'h1000;
      d_wdata = 32'h0;
      if_req  = 1'b1;
      d_req   = 1'b1;
      dc      = 0;
      n       = 0;
      while ((if_req || d_req) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (d_ack === 1'b1) begin
            dc++;
            d_addr = 32'h1000 + 32'(dc * 4);
         end else if (dc >= nd) begin
            d_req = 1'b0;
         end
         if (if_ack === 1'b1) if_req = 1'b0;
      end
      check("starve_data_grants", 64'(dc), 64'(nd));
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   task automatic run_reset_mid_data();
      int seen;
      int n;
      int acks;
      cmd_q.push_back(make_cmd(1'b0, 1'b1, 4'h3, 32'h400, 32'h1234_5678, 3));
      d_we    = 1'b1;
      d_sel   = 4'h3;
      d_addr  = 32'h400;
      d_wdata = 32'h1234_5678;
      d_req   = 1'b1;
      seen    = 0;
      n       = 0;
      while (seen < 2 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (bus_ce === 1'b1) seen++;
      end
      check("reset_reached_wait", 64'(seen), 64'd2);
      rst   = 1'b0;
      d_req = 1'b0;
      @(posedge clk);
      #1;
      check("mid_reset_ce", 64'(bus_ce), 64'd0);
      check("mid_reset_acks", 64'({if_ack, d_ack, err}), 64'd0);
      check("mid_reset_cmd", {bus_we, bus_sel, bus_addr}, 64'd0);
      check("mid_reset_wdata", bus_wdata, 64'd0);
      check("mid_reset_rdata", {if_rdata, d_rdata}, 64'd0);
      starve_m = 0;
      rst      = 1'b1;
      late_ack = 1'b1;
      acks     = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (if_ack === 1'b1 || d_ack === 1'b1 || err === 1'b1) acks++;
      end
      late_ack = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (if_ack === 1'b1 || d_ack === 1'b1 || err === 1'b1) acks++;
      end
      check("late_ack_ignored", 64'(acks), 64'd0);
   endtask

   initial begin : stimulus
      int lat;
      int ce;
      int kind;
      int r;
      int w;
      int fw;
      bit do_f;
      bit do_d;
      rst     = 1'b0;
      if_req  = 1'b0;
      if_addr = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_sel   = 4'h0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 64'({bus_ce, bus_we, if_ack, d_ack, err}), 64'd0);
      check("reset_cmd", {bus_sel, bus_addr}, 64'd0);
      check("reset_wdata", bus_wdata, 64'd0);
      check("reset_rdata", {if_rdata, d_rdata}, 64'd0);
      rst = 1'b1;

      run_episode(1'b1, 1'b0, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, lat, ce);
      check("fetch_latency", 64'(lat), 64'd2);
      check("fetch_rdata_hold", if_rdata, 32'h2402_0001);

      run_episode(1'b1, 1'b1, 32'h80, 1'b0, 4'hF, 32'h100, 32'h0, 1, 2, lat, ce);

      run_starvation();

      run_episode(1'b0, 1'b1, 32'h0, 1'b1, 4'h3, 32'h200, 32'hCAFE_F00D, 0, TIMEOUT, lat, ce);
      check("timeout_ce_cycles", 64'(ce), 64'(TIMEOUT));
      check("timeout_latency", 64'(lat), 64'(TIMEOUT + 1));

      run_episode(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h204, 32'h0, 0, TIMEOUT - 1, lat, ce);
      check("last_cycle_ack_latency", 64'(lat), 64'(TIMEOUT + 1));

      run_reset_mid_data();

      run_episode(1'b0, 1'b1, 32'h0, 1'b0, 4'h1, 32'h500, 32'h0, 0, 0, lat, ce);
      check("post_reset_latency", 64'(lat), 64'd2);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         do_f = (kind != 1);
         do_d = (kind != 0);
         r    = $urandom_range(0, 15);
         w    = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
         fw   = $urandom_range(0, 3);
         run_episode(do_f, do_d, {$urandom_range(0, 65535), 2'b00}, 1'($urandom_range(0, 1)),
                     4'($urandom_range(1, 15)), {$urandom_range(0, 65535), 2'b00}, $urandom(),
                     fw, w, lat, ce);
         if (do_d && !do_f)
            check("rand_data_latency", 64'(lat), 64'(((w >= TIMEOUT) ? TIMEOUT - 1 : w) + 2));
         if (do_f && !do_d)
            check("rand_fetch_latency", 64'(lat), 64'(fw + 2));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("commands_drained", 64'(cmd_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
